// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the RSA exponentiation controller.
// Default widths match the 192-bit mont_exp engine and 32-bit host stream.
package rsa_pkg;

    localparam int RSA_WIDTH           = 192;
    localparam int RSA_WORD            = 32;
    localparam int RSA_NW              = RSA_WIDTH / RSA_WORD;
    localparam int RSA_TIMEOUT_DEFAULT = 65536;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } rsa_ctrl_state_t;

endpackage

// File: rtl/rsa_word_unpack.sv
// WIDTH->WORD selector: returns word idx_i of data_i, zero for out-of-range idx_i.
// Purely combinational; no handshake of its own.
module rsa_word_unpack
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int WORD  = RSA_WORD,
    parameter int IW    = 4
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [IW-1:0]    idx_i,
    output logic [WORD-1:0]  word_o
);

    localparam int NW = WIDTH / WORD;

    always_comb begin
        word_o = '0;
        for (int i = 0; i < NW; i++) begin
            if (idx_i == IW'(i)) begin
                word_o = data_i[i*WORD +: WORD];
            end
        end
    end

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Stream-side controller for mont_exp: loads x/y word-serially, runs the engine, streams z out.
// Optional run watchdog enabled by defining RSA_CTRL_TIMEOUT_EN.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH   = RSA_WIDTH,
    parameter int WORD    = RSA_WORD,
    parameter int TIMEOUT = RSA_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WORD-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WORD-1:0]  m_data,
    output logic [WIDTH-1:0] exp_x,
    output logic [WIDTH-1:0] exp_y,
    output logic             exp_start,
    input  logic [WIDTH-1:0] exp_z,
    input  logic             exp_done,
    output logic             busy,
    output logic             err
);

    localparam int NW  = WIDTH / WORD;
    localparam int WCW = $clog2(2 * NW);
    localparam logic [WCW-1:0] WC_NW       = WCW'(NW);
    localparam logic [WCW-1:0] WC_LAST_IN  = WCW'(2 * NW - 1);
    localparam logic [WCW-1:0] WC_LAST_OUT = WCW'(NW - 1);

    rsa_ctrl_state_t  state_q, state_d;
    logic [WCW-1:0]   wc_q, wc_d;
    logic [WIDTH-1:0] x_q, y_q;
    logic [WIDTH-1:0] zr_q, zr_d;
    logic             start_q, start_d;
    logic             load_fire;
    logic [WCW-1:0]   wc_lo;
    logic             tmo_hit;

    assign load_fire = (state_q == LOAD) && s_valid;
    assign wc_lo     = (wc_q < WC_NW) ? wc_q : (wc_q - WC_NW);

`ifdef RSA_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    // Counter is held at zero outside RUN, so it restarts on every RUN entry.
    always_comb begin
        tmo_d = '0;
        err_d = err_q;
        if (state_q == RUN) begin
            tmo_d = tmo_q + TW'(1);
            if (!exp_done && tmo_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            wc_q    <= '0;
            zr_q    <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            zr_q    <= zr_d;
            start_q <= start_d;
        end
    end

    // Operands are only written in LOAD, so they hold steady through ARM/RUN/DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (load_fire) begin
            for (int i = 0; i < NW; i++) begin
                if (wc_lo == WCW'(i)) begin
                    if (wc_q < WC_NW) begin
                        x_q[i*WORD +: WORD] <= s_data;
                    end else begin
                        y_q[i*WORD +: WORD] <= s_data;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        zr_d    = zr_q;
        start_d = start_q;
        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    if (wc_q == WC_LAST_IN) begin
                        wc_d    = '0;
                        state_d = ARM;
                    end else begin
                        wc_d = wc_q + WCW'(1);
                    end
                end
            end
            // A done still high from the previous run must clear before restarting.
            ARM: begin
                if (!exp_done) begin
                    start_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (exp_done) begin
                    zr_d    = exp_z;
                    start_d = 1'b0;
                    state_d = DRAIN;
                end else if (tmo_hit) begin
                    zr_d    = '0;
                    start_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (wc_q == WC_LAST_OUT) begin
                        wc_d    = '0;
                        state_d = LOAD;
                    end else begin
                        wc_d = wc_q + WCW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
                wc_d    = '0;
                start_d = 1'b0;
            end
        endcase
    end

    rsa_word_unpack #(
        .WIDTH (WIDTH),
        .WORD  (WORD),
        .IW    (WCW)
    ) u_unpack (
        .data_i (zr_q),
        .idx_i  (wc_q),
        .word_o (m_data)
    );

    assign s_ready   = (state_q == LOAD);
    assign m_valid   = (state_q == DRAIN);
    assign busy      = (state_q != LOAD);
    assign exp_start = start_q;
    assign exp_x     = x_q;
    assign exp_y     = y_q;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl with a behavioural mont_exp model and an output scoreboard.
// Run with RSA_CTRL_TIMEOUT_EN defined to also exercise the watchdog path.
module tb_rsa_exp_ctrl;
    import rsa_pkg::*;

    localparam int W  = 192;
    localparam int WD = 32;

    localparam logic [W-1:0] Z11 = 192'h00000000000009A5_FFFFFFFFFFFFF65A_0000000000000000;
    localparam logic [W-1:0] Z2  = 192'h11111111_22222222_33333333_44444444_55555555_66666666;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [WD-1:0] s_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [WD-1:0] m_data;
    logic [W-1:0]  exp_x, exp_y, exp_z;
    logic          exp_start;
    logic          exp_done = 1'b0;
    logic          busy, err;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } op_t;

    logic [31:0] exp_q[$];
    op_t         op_q[$];
    int          total = 0;
    int          bad   = 0;

    logic [31:0] zw11 [6] = '{32'h00000000, 32'h00000000, 32'hFFFFF65A,
                              32'hFFFFFFFF, 32'h000009A5, 32'h00000000};
    logic [31:0] zw2  [6] = '{32'h66666666, 32'h55555555, 32'h44444444,
                              32'h33333333, 32'h22222222, 32'h11111111};

    always #5 clk = ~clk;

    rsa_exp_ctrl #(.WIDTH(W), .WORD(WD), .TIMEOUT(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .exp_x     (exp_x),
        .exp_y     (exp_y),
        .exp_start (exp_start),
        .exp_z     (exp_z),
        .exp_done  (exp_done),
        .busy      (busy),
        .err       (err)
    );

    // Behavioural engine: done L cycles after start rises, optionally held m_hold cycles after start falls.
    int m_lat   = 8;
    int m_hold  = 0;
    bit m_never = 1'b0;
    int mcnt    = 0;
    int hcnt    = 0;

    always @(posedge clk) begin
        if (exp_start) begin
            hcnt <= m_hold;
            if (!m_never && mcnt >= m_lat - 1) exp_done <= 1'b1;
            else mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
            if (hcnt != 0) hcnt <= hcnt - 1;
            else exp_done <= 1'b0;
        end
    end

    always_comb begin
        if (exp_x == W'(11) && exp_y == W'(11)) exp_z = Z11;
        else if (exp_x == W'(2) && exp_y == W'(2)) exp_z = Z2;
        else exp_z = '1;
    end

    // Downstream ready: pattern 1-0-0-1 while backpressure is enabled.
    bit       bp_en = 1'b0;
    int       bp_ph = 0;
    bit [3:0] bp_pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        m_ready = bp_en ? bp_pat[bp_ph] : 1'b1;
        bp_ph   = (bp_ph + 1) % 4;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: scoreboard pop on output handshake, stall stability, operand check on start rise.
    logic        prev_start = 1'b0;
    logic        prev_done  = 1'b0;
    bit          stall_pend = 1'b0;
    logic [31:0] stall_dat;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_pend) chk("stall_hold", {m_valid, m_data}, {1'b1, stall_dat});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("extra_word", W'(m_data), '1);
                else chk("m_data", W'(m_data), W'(exp_q.pop_front()));
            end
            stall_pend = m_valid && !m_ready;
            stall_dat  = m_data;
            if (exp_start && !prev_start) begin
                op_t o;
                chk("start_after_done_low", W'(prev_done), '0);
                if (op_q.size() == 0) chk("unexpected_start", '0, '1);
                else begin
                    o = op_q.pop_front();
                    chk("op_x", exp_x, o.x);
                    chk("op_y", exp_y, o.y);
                end
            end
            if (exp_start) chk("s_ready_run", W'(s_ready), '0);
        end else begin
            stall_pend = 1'b0;
        end
        prev_start = exp_start;
        prev_done  = exp_done;
    end

    task automatic send(input logic [31:0] w, input int gap);
        int n;
        bit ok;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        forever begin
            ok = s_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 2000) begin
                chk("send_timeout", '0, '1);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] x, input logic [W-1:0] y, input bit gaps);
        op_q.push_back('{x: x, y: y});
        for (int i = 0; i < 12; i++) begin
            send(i < 6 ? x[i*32 +: 32] : y[(i-6)*32 +: 32], gaps ? (i % 3) : 0);
        end
    endtask

    task automatic push_words(input logic [31:0] zw [6]);
        for (int i = 0; i < 6; i++) exp_q.push_back(zw[i]);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= bound) chk("idle_timeout", '0, '1);
    endtask

    task automatic wait_start(input int bound);
        int n = 0;
        while (!exp_start && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= bound) chk("start_timeout", '0, '1);
    endtask

    logic [31:0] zeros [6] = '{default: 32'h0};

    initial begin
        int n;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        #1;
        chk("rst_s_ready",   W'(s_ready),   W'(1));
        chk("rst_m_valid",   W'(m_valid),   '0);
        chk("rst_m_data",    W'(m_data),    '0);
        chk("rst_exp_x",     exp_x,         '0);
        chk("rst_exp_y",     exp_y,         '0);
        chk("rst_exp_start", W'(exp_start), '0);
        chk("rst_busy",      W'(busy),      '0);
        chk("rst_err",       W'(err),       '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: x = y = 11, with ARM/start/done timing
        push_words(zw11);
        load(W'(11), W'(11), 1'b0);
        chk("arm_busy",  W'(busy),      W'(1));
        chk("arm_start", W'(exp_start), '0);
        chk("arm_x",     exp_x,         W'(11));
        chk("arm_y",     exp_y,         W'(11));
        @(posedge clk); #1;
        chk("start_rise", W'(exp_start), W'(1));
        n = 0;
        while (!exp_done && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("done_timeout", '0, '1);
        @(posedge clk); #1;
        chk("drain_m_valid", W'(m_valid),   W'(1));
        chk("drain_start",   W'(exp_start), '0);
        wait_idle(500);

        // 2: back-to-back runs with done held long after start falls
        m_hold = 30;
        push_words(zw2);
        push_words(zw11);
        load(W'(2), W'(2), 1'b0);
        load(W'(11), W'(11), 1'b0);
        wait_idle(2000);
        m_hold = 0;

        // 3: output backpressure
        bp_en = 1'b1;
        push_words(zw11);
        load(W'(11), W'(11), 1'b0);
        wait_idle(2000);
        bp_en = 1'b0;

        // 4: input gaps
        push_words(zw11);
        load(W'(11), W'(11), 1'b1);
        wait_idle(2000);

        // 5: reset at cycle 20 of the engine latency
        m_lat = 40;
        load(W'(2), W'(2), 1'b0);
        wait_start(500);
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_start", W'(exp_start), '0);
        chk("abort_busy",  W'(busy),      '0);
        chk("abort_x",     exp_x,         '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_lat = 8;
        @(posedge clk); #1;
        push_words(zw11);
        load(W'(11), W'(11), 1'b0);
        wait_idle(2000);

`ifdef RSA_CTRL_TIMEOUT_EN
        // 6: engine never completes; watchdog fires at the 100th RUN cycle
        m_never = 1'b1;
        push_words(zeros);
        load(W'(2), W'(2), 1'b0);
        wait_start(500);
        n = 0;
        while (exp_start && n < 300) begin n++; @(posedge clk); #1; end
        chk("tmo_run_cycles", W'(n),   W'(100));
        chk("tmo_err",        W'(err), W'(1));
        wait_idle(500);
        chk("tmo_err_sticky", W'(err),  W'(1));
        chk("tmo_back_load",  W'(busy), '0);
        m_never = 1'b0;
`else
        chk("err_tied_low", W'(err), '0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("words_left", W'(exp_q.size()), '0);
        chk("ops_left",   W'(op_q.size()),  '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Stream-side controller for the modular-exponentiation engine `mont_exp`. It receives operands over a 32-bit valid/ready input stream and assembles the 192-bit `x` and `y` operands. It then drives `mont_exp`'s `start`/`done` handshake and streams the 192-bit result `z` back out as 32-bit words. It is the initiator for `mont_exp` and sits between the host bus adapter and the engine.

## Interface
Parameters:
- `WIDTH`, default 192: operand/result width in bits.
- `WORD`, default 32: stream word width; `WIDTH % WORD == 0`.
- `TIMEOUT`, default 65536: watchdog limit in cycles (used only with the timeout feature).

Ports:
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  controller accepts the input word.
- `s_data`  in  WORD  operand word.
- `m_valid`  out  1  result word valid.
- `m_ready`  in  1  downstream accepts the result word.
- `m_data`  out  WORD  result word.
- `exp_x`  out  WIDTH  engine operand x (registered).
- `exp_y`  out  WIDTH  engine operand y (registered).
- `exp_start`  out  1  engine start (level).
- `exp_z`  in  WIDTH  engine result.
- `exp_done`  in  1  engine completion.
- `busy`  out  1  high in any state other than LOAD.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- NW = WIDTH/WORD (6 at the default values). Each operand is received least-significant word first.
- States: LOAD, ARM, RUN, DRAIN.
- **LOAD**
  - `s_ready` = 1.
  - Word count `wc` runs 0..2·NW−1.
  - Words 0..NW−1 fill `exp_x`; words NW..2·NW−1 fill `exp_y`.
  - Word k is written to bits [(k mod NW)·WORD +: WORD] of the selected operand.
  - On acceptance of word 2·NW−1: `wc` returns to 0 and the state moves to ARM.
- **ARM**
  - Waits for `exp_done` = 0, so a stale `done` from the previous run cannot be taken as completion.
  - When `exp_done` = 0: assert `exp_start` and go to RUN.
- **RUN**
  - `exp_start` is held high.
  - On the first cycle with `exp_done` = 1: capture `exp_z` into the result register `zr`, drop `exp_start`, go to DRAIN.
- **DRAIN**
  - `m_valid` = 1 and `m_data` = `zr[wc·WORD +: WORD]`.
  - `wc` advances on each `m_valid && m_ready`.
  - After word NW−1 is accepted: `wc` returns to 0 and the state goes to LOAD.
- `exp_x` and `exp_y` are stable from entry to ARM until the next LOAD write.
- Operand words are accepted only in LOAD. `s_ready` = 0 elsewhere; input held while `s_ready` = 0 is not consumed.
- `m_valid` is never dropped before its word is accepted, and `m_data` is stable while stalled.

## Timing
- Reset values: `s_ready` = 1, `m_valid` = 0, `m_data` = 0, `exp_x` = 0, `exp_y` = 0, `exp_start` = 0, `busy` = 0, `err` = 0. State = LOAD, `wc` = 0, `zr` = 0.
- Last input word accepted at edge n → ARM in cycle n+1.
- With `exp_done` low in ARM, `exp_start` rises at edge n+1 (visible in cycle n+2).
- `exp_done` sampled high at edge d → `exp_start` = 0 and `m_valid` = 1 from cycle d+1.
- Minimum overhead, excluding engine time: 2·NW input cycles + 2 + NW output cycles.
- `exp_done` is ignored outside RUN.
- Reset mid-operation aborts immediately: `exp_start` goes low asynchronously and partially loaded operands are discarded.

## Configuration
- Macro `RSA_CTRL_TIMEOUT_EN`.
- **Defined:** a counter clears on entry to RUN and increments each RUN cycle. If it reaches `TIMEOUT` without `exp_done`:
  - set `err`;
  - drop `exp_start`;
  - load `zr` = 0;
  - go to DRAIN, which outputs NW zero words.
- **Undefined:** no counter; RUN waits indefinitely; `err` is tied to 0.

## Structure
- Shared package `rsa_pkg`:
  - `RSA_WIDTH` = 192, `RSA_WORD` = 32, `RSA_NW` = 6;
  - state enum `rsa_ctrl_state_t` (LOAD, ARM, RUN, DRAIN);
  - `RSA_TIMEOUT_DEFAULT`.
- Sub-module `rsa_word_unpack`: parameterised WIDTH→WORD selector (`zr`, `wc` → `m_data`). The same selector is reused later by the host-side readback path. All control stays in `rsa_exp_ctrl`.

## Test plan
The bench uses a behavioural `mont_exp` model that raises `done` L cycles after `start` rises and holds it until `start` falls.
1. Load x = 11, y = 11 (words `0000000B`,0,0,0,0,0 twice); model returns `z` = 0x00000000000009A5_FFFFFFFFFFFFF65A_0000000000000000.
   - Required: `exp_x` = `exp_y` = 11 in ARM.
   - Required: `m_data` sequence is `00000000`,`00000000`,`FFFFF65A`,`FFFFFFFF`,`000009A5`,`00000000`.
2. Back-to-back runs: x = y = 2, then x = y = 11 with no idle cycles. Required: the second `exp_start` does not rise until the model drops `done`, and both results stream out in order.
3. Backpressure: `m_ready` toggles 1-0-0-1 during DRAIN. Required: `m_data` is held stable while stalled and no word is dropped or duplicated.
4. Input stalls: `s_valid` gaps between words. Required: operands are assembled identically to scenario 1 and `s_ready` = 0 in RUN.
5. Reset asserted during RUN at cycle 20 of the model's latency. Required: `exp_start` = 0 and `busy` = 0 immediately, and a subsequent full load works.
6. With `RSA_CTRL_TIMEOUT_EN`, `TIMEOUT` = 100, model never raises `done`. Required:
   - `err` = 1 and `exp_start` drops at the 100th RUN cycle;
   - six zero words are output;
   - state returns to LOAD with `err` still set.
